// File: rtl/mc_pkg.sv
// mc_pkg: shared encodings for the multi-cycle MIPS-subset control unit.
// State codes, opcode/func constants, datapath select codes and the
// one-hot instruction-class record produced by mc_decode.
package mc_pkg;

    // FSM state codes; also exported on the debug state port.
    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4
    } state_t;

    // Primary opcodes (IR[31:26]).
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    // R-type function codes (IR[5:0]).
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_JR  = 6'b001000;

    // ALU operation select.
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_OR  = 3'b010;
    localparam logic [2:0] ALU_LUI = 3'b011;

    // Register-file destination select.
    localparam logic [1:0] WR_RT = 2'b00;
    localparam logic [1:0] WR_RD = 2'b01;
    localparam logic [1:0] WR_RA = 2'b10;

    // Register-file write-data select.
    localparam logic [1:0] WD_ALU = 2'b00;
    localparam logic [1:0] WD_DM  = 2'b01;
    localparam logic [1:0] WD_PC  = 2'b10;

    // Next-PC select.
    localparam logic [1:0] NPC_SEQ = 2'b00;
    localparam logic [1:0] NPC_BR  = 2'b01;
    localparam logic [1:0] NPC_J   = 2'b10;
    localparam logic [1:0] NPC_JR  = 2'b11;

    // One-hot instruction class; all-zero means unrecognised.
    typedef struct packed {
        logic add;
        logic sub;
        logic ori;
        logic lw;
        logic sw;
        logic lui;
        logic beq;
        logic jal;
        logic jr;
    } iclass_t;

    // ALU operation for the EXEC cycle of a given instruction class.
    // Loads and stores use add for address generation.
    function automatic logic [2:0] alu_op_of(input iclass_t c);
        if (c.sub || c.beq) return ALU_SUB;
        if (c.ori)          return ALU_OR;
        if (c.lui)          return ALU_LUI;
        return ALU_ADD;
    endfunction

endpackage

// File: rtl/mc_decode.sv
// mc_decode: combinational opcode/func decode into one-hot instruction
// class flags plus an illegal flag for anything outside the subset.
module mc_decode
    import mc_pkg::*;
(
    input  logic [5:0] i_opcode,
    input  logic [5:0] i_func,
    output iclass_t    o_cls,
    output logic       o_illegal
);

    iclass_t w_cls;

    // Map opcode (and func for R-type) onto exactly one class flag.
    always_comb begin
        w_cls = '0;
        case (i_opcode)
            OP_RTYPE: begin
                case (i_func)
                    FN_ADD:  w_cls.add = 1'b1;
                    FN_SUB:  w_cls.sub = 1'b1;
                    FN_JR:   w_cls.jr  = 1'b1;
                    default: w_cls     = '0;
                endcase
            end
            OP_ORI:  w_cls.ori = 1'b1;
            OP_LW:   w_cls.lw  = 1'b1;
            OP_SW:   w_cls.sw  = 1'b1;
            OP_LUI:  w_cls.lui = 1'b1;
            OP_BEQ:  w_cls.beq = 1'b1;
            OP_JAL:  w_cls.jal = 1'b1;
            default: w_cls     = '0;
        endcase
    end

    assign o_cls     = w_cls;
    assign o_illegal = (w_cls == '0);

endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle control unit for the MIPS-subset datapath.
// Five-state FSM sequencing FETCH/DECODE/EXEC/MEM/WB over a shared ALU,
// register file and memory port, with a mem_rdy stall handshake.
// Optional retired-instruction counter: define MC_CTRL_INSTRET_EN.
//
// state  | meaning
// FETCH  | memory read of instruction; IR/PC load when mem_rdy
// DECODE | jal/jr complete here; illegal opcodes pulse illegal and drop
// EXEC   | ALU operation; beq resolves here
// MEM    | lw/sw data access, held until mem_rdy
// WB     | register-file write for ALU and load results
module mc_ctrl
    import mc_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic [5:0]  opcode,
    input  logic [5:0]  func,
    input  logic        zero,
    input  logic        mem_rdy,
    output logic        PCWr,
    output logic [1:0]  NPCSel,
    output logic        IRWr,
    output logic        RFWr,
    output logic [1:0]  WRSel,
    output logic [1:0]  WDSel,
    output logic        BSel,
    output logic        EXTOP,
    output logic [2:0]  ALUOP,
    output logic        DMWr,
    output logic        DMRd,
    output logic [2:0]  state,
    output logic        illegal,
    output logic [31:0] instret
);

    state_t      r_state;
    state_t      w_next;
    iclass_t     w_cls;
    logic        w_dec_illegal;

    logic        w_pcwr;
    logic [1:0]  w_npcsel;
    logic        w_irwr;
    logic        w_rfwr;
    logic [1:0]  w_wrsel;
    logic [1:0]  w_wdsel;
    logic        w_bsel;
    logic        w_extop;
    logic [2:0]  w_aluop;
    logic        w_dmwr;
    logic        w_dmrd;
    logic        w_illegal;

    mc_decode u_decode (
        .i_opcode  (opcode),
        .i_func    (func),
        .o_cls     (w_cls),
        .o_illegal (w_dec_illegal)
    );

    // State register; reset abandons any instruction in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and per-cycle control outputs from state and instruction class.
    always_comb begin
        w_next    = ST_FETCH;
        w_pcwr    = 1'b0;
        w_npcsel  = NPC_SEQ;
        w_irwr    = 1'b0;
        w_rfwr    = 1'b0;
        w_wrsel   = WR_RT;
        w_wdsel   = WD_ALU;
        w_bsel    = 1'b0;
        w_extop   = 1'b0;
        w_aluop   = ALU_ADD;
        w_dmwr    = 1'b0;
        w_dmrd    = 1'b0;
        w_illegal = 1'b0;

        case (r_state)
            ST_FETCH: begin
                w_irwr = mem_rdy;
                w_pcwr = mem_rdy;
                w_next = mem_rdy ? ST_DECODE : ST_FETCH;
            end

            ST_DECODE: begin
                if (w_cls.jal) begin
                    // PC in the datapath already holds PC+4, which is the link value.
                    w_rfwr   = 1'b1;
                    w_wrsel  = WR_RA;
                    w_wdsel  = WD_PC;
                    w_pcwr   = 1'b1;
                    w_npcsel = NPC_J;
                end else if (w_cls.jr) begin
                    w_pcwr   = 1'b1;
                    w_npcsel = NPC_JR;
                end else if (w_dec_illegal) begin
                    w_illegal = 1'b1;
                end else begin
                    w_next = ST_EXEC;
                end
            end

            ST_EXEC: begin
                w_aluop = alu_op_of(w_cls);
                w_bsel  = w_cls.ori | w_cls.lui | w_cls.lw | w_cls.sw;
                w_extop = w_cls.ori | w_cls.lui;
                if (w_cls.beq) begin
                    // Not-taken leaves PC at the PC+4 written during FETCH.
                    w_pcwr   = zero;
                    w_npcsel = NPC_BR;
                    w_next   = ST_FETCH;
                end else if (w_cls.lw || w_cls.sw) begin
                    w_next = ST_MEM;
                end else begin
                    w_next = ST_WB;
                end
            end

            ST_MEM: begin
                if (w_cls.lw) begin
                    w_dmrd = 1'b1;
                    w_next = mem_rdy ? ST_WB : ST_MEM;
                end else if (w_cls.sw) begin
                    w_dmwr = 1'b1;
                    w_next = mem_rdy ? ST_FETCH : ST_MEM;
                end else begin
                    w_next = ST_FETCH;
                end
            end

            ST_WB: begin
                w_rfwr  = 1'b1;
                w_wrsel = (w_cls.add || w_cls.sub) ? WR_RD : WR_RT;
                w_wdsel = w_cls.lw ? WD_DM : WD_ALU;
                w_next  = ST_FETCH;
            end

            default: begin
                w_next = ST_FETCH;
            end
        endcase
    end

    // Enables and selects are held inactive for the whole time reset is low,
    // independent of mem_rdy, so nothing in the datapath moves during reset.
    assign PCWr    = reset_n & w_pcwr;
    assign IRWr    = reset_n & w_irwr;
    assign RFWr    = reset_n & w_rfwr;
    assign DMWr    = reset_n & w_dmwr;
    assign DMRd    = reset_n & w_dmrd;
    assign illegal = reset_n & w_illegal;
    assign NPCSel  = reset_n ? w_npcsel : NPC_SEQ;
    assign WRSel   = reset_n ? w_wrsel  : WR_RT;
    assign WDSel   = reset_n ? w_wdsel  : WD_ALU;
    assign BSel    = reset_n & w_bsel;
    assign EXTOP   = reset_n & w_extop;
    assign ALUOP   = reset_n ? w_aluop  : ALU_ADD;
    assign state   = r_state;

`ifdef MC_CTRL_INSTRET_EN
    logic [31:0] r_instret;
    logic        w_retire;

    // An instruction retires on its last cycle: a real work state heading
    // back to FETCH, excluding the illegal-opcode drop in DECODE.
    assign w_retire = (r_state != ST_FETCH) && (r_state <= ST_WB) &&
                      (w_next == ST_FETCH) && !w_illegal;

    // Retired-instruction counter, wraps naturally at 2^32.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_instret <= 32'd0;
        end else if (w_retire) begin
            r_instret <= r_instret + 32'd1;
        end
    end

    assign instret = r_instret;
`else
    assign instret = 32'd0;
`endif

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: randomized self-checking bench for mc_ctrl. Each instruction
// is expanded into the list of cycles it must occupy (fetch stalls, decode,
// exec, memory stalls, writeback) and every cycle's outputs are compared
// against values derived from the instruction's behaviour.
`timescale 1ns/1ps
module tb_mc_ctrl;

    localparam int K_ADD = 0, K_SUB = 1, K_ORI = 2, K_LW = 3, K_SW = 4,
                   K_LUI = 5, K_BEQ = 6, K_JAL = 7, K_JR = 8, K_ILL = 9;
    localparam int P_FS = 0, P_F = 1, P_D = 2, P_E = 3, P_MS = 4, P_M = 5, P_W = 6;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [5:0]  opcode = 6'd0;
    logic [5:0]  func = 6'd0;
    logic        zero = 1'b0;
    logic        mem_rdy = 1'b0;
    logic        PCWr, IRWr, RFWr, BSel, EXTOP, DMWr, DMRd, illegal;
    logic [1:0]  NPCSel, WRSel, WDSel;
    logic [2:0]  ALUOP, state;
    logic [31:0] instret;

    int total = 0;
    int bad = 0;
    int retired = 0;
    string knames[10] = '{"add", "sub", "ori", "lw", "sw", "lui", "beq", "jal", "jr", "ill"};

    mc_ctrl dut (
        .clk     (clk),
        .reset_n (reset_n),
        .opcode  (opcode),
        .func    (func),
        .zero    (zero),
        .mem_rdy (mem_rdy),
        .PCWr    (PCWr),
        .NPCSel  (NPCSel),
        .IRWr    (IRWr),
        .RFWr    (RFWr),
        .WRSel   (WRSel),
        .WDSel   (WDSel),
        .BSel    (BSel),
        .EXTOP   (EXTOP),
        .ALUOP   (ALUOP),
        .DMWr    (DMWr),
        .DMRd    (DMRd),
        .state   (state),
        .illegal (illegal),
        .instret (instret)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pack(input logic [2:0] st, input logic pcwr, input logic [1:0] npc,
                                         input logic irwr, input logic rfwr, input logic [1:0] wrs,
                                         input logic [1:0] wds, input logic bs, input logic ext,
                                         input logic [2:0] alu, input logic dmwr, input logic dmrd,
                                         input logic ill);
        return {12'd0, st, pcwr, npc, irwr, rfwr, wrs, wds, bs, ext, alu, dmwr, dmrd, ill};
    endfunction

    function automatic logic [31:0] obs();
        return pack(state, PCWr, NPCSel, IRWr, RFWr, WRSel, WDSel, BSel, EXTOP, ALUOP, DMWr, DMRd, illegal);
    endfunction

    // Outputs required for one cycle of instruction k in phase ph.
    function automatic logic [31:0] exp_out(input int ph, input int k, input logic z);
        logic [2:0] st = 3'd0, alu = 3'd0;
        logic [1:0] npc = 2'd0, wrs = 2'd0, wds = 2'd0;
        logic pcwr = 0, irwr = 0, rfwr = 0, bs = 0, ext = 0, dmwr = 0, dmrd = 0, ill = 0;
        case (ph)
            P_FS: st = 3'd0;
            P_F:  begin st = 3'd0; pcwr = 1; irwr = 1; end
            P_D: begin
                st = 3'd1;
                if (k == K_JAL) begin rfwr = 1; wrs = 2'b10; wds = 2'b10; pcwr = 1; npc = 2'b10; end
                else if (k == K_JR) begin pcwr = 1; npc = 2'b11; end
                else if (k == K_ILL) ill = 1;
            end
            P_E: begin
                st = 3'd2;
                case (k)
                    K_SUB:       alu = 3'b001;
                    K_ORI:       begin alu = 3'b010; bs = 1; ext = 1; end
                    K_LUI:       begin alu = 3'b011; bs = 1; ext = 1; end
                    K_LW, K_SW:  bs = 1;
                    K_BEQ:       begin alu = 3'b001; pcwr = z; npc = 2'b01; end
                    default:     alu = 3'b000;
                endcase
            end
            P_MS, P_M: begin st = 3'd3; dmrd = (k == K_LW); dmwr = (k == K_SW); end
            P_W: begin
                st = 3'd4; rfwr = 1;
                wrs = (k == K_ADD || k == K_SUB) ? 2'b01 : 2'b00;
                wds = (k == K_LW) ? 2'b01 : 2'b00;
            end
            default: st = 3'd0;
        endcase
        return pack(st, pcwr, npc, irwr, rfwr, wrs, wds, bs, ext, alu, dmwr, dmrd, ill);
    endfunction

    // Random opcode/func outside the supported subset.
    task automatic pick_illegal(output logic [5:0] op, output logic [5:0] fn);
        op = 6'h3f;
        fn = 6'($urandom);
        if ($urandom_range(0, 1) == 1) begin
            for (int t = 0; t < 100; t++) begin
                logic legal;
                op = 6'($urandom_range(0, 7) == 0 ? 0 : $urandom);
                fn = 6'($urandom);
                if (op == 6'd0) legal = (fn == 6'b100000 || fn == 6'b100010 || fn == 6'b001000);
                else legal = (op == 6'b001101 || op == 6'b100011 || op == 6'b101011 ||
                              op == 6'b001111 || op == 6'b000100 || op == 6'b000011);
                if (!legal) break;
                op = 6'h3f;
            end
        end
    endtask

    task automatic set_instr(input int k);
        logic [5:0] op, fn;
        fn = 6'($urandom);
        case (k)
            K_ADD: begin op = 6'b000000; fn = 6'b100000; end
            K_SUB: begin op = 6'b000000; fn = 6'b100010; end
            K_JR:  begin op = 6'b000000; fn = 6'b001000; end
            K_ORI: op = 6'b001101;
            K_LW:  op = 6'b100011;
            K_SW:  op = 6'b101011;
            K_LUI: op = 6'b001111;
            K_BEQ: op = 6'b000100;
            K_JAL: op = 6'b000011;
            default: pick_illegal(op, fn);
        endcase
        opcode = op;
        func   = fn;
    endtask

    // Drive one cycle: inputs just after the rising edge, check at the falling edge.
    task automatic do_cycle(input int ph, input int k, input logic z, input string tag);
        @(posedge clk);
        #1;
        if (ph == P_FS || ph == P_MS) mem_rdy = 1'b0;
        else if (ph == P_F || ph == P_M) mem_rdy = 1'b1;
        else mem_rdy = 1'($urandom);
        zero = z;
        @(negedge clk);
        check(tag, obs(), exp_out(ph, k, z));
    endtask

    task automatic check_instret(input string tag);
`ifdef MC_CTRL_INSTRET_EN
        check(tag, instret, 32'(retired));
`else
        check(tag, instret, 32'd0);
`endif
    endtask

    task automatic run_instr(input int k, input logic z, input int fw, input int mw);
        int q[$];
        set_instr(k);
        repeat (fw) q.push_back(P_FS);
        q.push_back(P_F);
        q.push_back(P_D);
        case (k)
            K_BEQ: q.push_back(P_E);
            K_ADD, K_SUB, K_ORI, K_LUI: begin q.push_back(P_E); q.push_back(P_W); end
            K_LW: begin
                q.push_back(P_E);
                repeat (mw) q.push_back(P_MS);
                q.push_back(P_M);
                q.push_back(P_W);
            end
            K_SW: begin
                q.push_back(P_E);
                repeat (mw) q.push_back(P_MS);
                q.push_back(P_M);
            end
            default: ;
        endcase
        foreach (q[i]) do_cycle(q[i], k, z, $sformatf("%s op=%h c%0d", knames[k], opcode, i));
        // Back in FETCH (stalled) right after the last cycle.
        do_cycle(P_FS, k, z, $sformatf("%s ret", knames[k]));
        if (k != K_ILL) retired++;
        check_instret($sformatf("%s instret", knames[k]));
    endtask

    // sw stalled in MEM, then reset asserted away from any clock edge.
    task automatic reset_mid_sw();
        set_instr(K_SW);
        do_cycle(P_F,  K_SW, 1'b0, "swrst fetch");
        do_cycle(P_D,  K_SW, 1'b0, "swrst decode");
        do_cycle(P_E,  K_SW, 1'b0, "swrst exec");
        do_cycle(P_MS, K_SW, 1'b0, "swrst memwait");
        #2;
        reset_n = 1'b0;
        #1;
        check("swrst dmwr_drop", {31'd0, DMWr}, 32'd0);
        check("swrst state", {29'd0, state}, 32'd0);
        mem_rdy = 1'b1;
        #1;
        check("swrst gated", obs(), 32'd0);
        @(posedge clk);
        #1;
        check("swrst hold", obs(), 32'd0);
        mem_rdy = 1'b0;
        retired = 0;
        check_instret("swrst instret");
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n = 1'b0;
        mem_rdy = 1'b1;
        @(negedge clk);
        check("reset outputs", obs(), 32'd0);
        check("reset instret", instret, 32'd0);
        mem_rdy = 1'b0;
        #2;
        reset_n = 1'b1;

        run_instr(K_ADD, 1'b0, 0, 0);
        run_instr(K_LW,  1'b0, 0, 2);
        run_instr(K_BEQ, 1'b1, 0, 0);
        run_instr(K_BEQ, 1'b0, 0, 0);
        run_instr(K_JAL, 1'b0, 0, 0);
        run_instr(K_JR,  1'b0, 0, 0);
        run_instr(K_ILL, 1'b0, 0, 0);
        run_instr(K_SW,  1'b0, 2, 1);
        reset_mid_sw();
        run_instr(K_ORI, 1'b0, 1, 0);
        run_instr(K_LUI, 1'b1, 0, 0);
        run_instr(K_SUB, 1'b0, 0, 0);

        repeat (250) begin
            int k, fw, mw;
            k  = $urandom_range(0, 9);
            fw = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
            mw = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
            run_instr(k, 1'($urandom), fw, mw);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Multi-cycle control unit for the MIPS-subset datapath (add, sub, ori, lw, sw, lui, beq, jal, jr). A five-state FSM sequences one shared ALU, register file and memory port across FETCH/DECODE/EXEC/MEM/WB. It drives per-cycle write enables and mux selects, and stalls on a memory ready handshake. It replaces the single-cycle decoder, with the same select encodings, so datapath muxes are reused unchanged.

## Interface
Parameters:
- none; all encodings come from the shared package.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- opcode  in  6  IR[31:26]; stable from DECODE through end of instruction.
- func  in  6  IR[5:0].
- zero  in  1  ALU result == 0.
- mem_rdy  in  1  memory completes access this cycle; used in FETCH and MEM.
- PCWr  out  1  PC write enable.
- NPCSel  out  2  next PC: 00 PC+4, 01 branch target, 10 jump target, 11 GPR[rs].
- IRWr  out  1  instruction register write enable.
- RFWr  out  1  register file write enable.
- WRSel  out  2  destination: 00 rt, 01 rd, 10 $31.
- WDSel  out  2  write data: 00 ALU result, 01 DM data, 10 PC (already PC+4).
- BSel  out  1  ALU B input: 0 GPR[rt], 1 extended immediate.
- EXTOP  out  1  1 zero-extend, 0 sign-extend.
- ALUOP  out  3  000 add, 001 sub, 010 or, 011 lui (B<<16).
- DMWr  out  1  data memory write request.
- DMRd  out  1  data memory read request.
- state  out  3  current state, for debug.
- illegal  out  1  one-cycle pulse in DECODE on an unrecognised instruction.
- instret  out  32  retired-instruction count; present only with the macro.

## Operation
States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4. Other codes go to FETCH on the next clock.
- FETCH: IRWr=PCWr=mem_rdy, NPCSel=00. Leave for DECODE when mem_rdy=1; stay otherwise.
- DECODE:
  - jal: RFWr=1, WRSel=10, WDSel=10, PCWr=1, NPCSel=10, then FETCH.
  - jr: PCWr=1, NPCSel=11, then FETCH.
  - Unrecognised instruction: illegal=1, no writes, then FETCH. It is treated as a nop.
  - All other instructions go to EXEC.
- EXEC:
  - add/sub: BSel=0.
  - ori/lui/lw/sw: BSel=1, EXTOP=1 for ori/lui, 0 otherwise.
  - ALUOP is per instruction class.
  - beq: ALUOP=001, PCWr=zero, NPCSel=01, then FETCH.
  - lw/sw go to MEM; others go to WB.
- MEM:
  - lw: DMRd=1; on mem_rdy go to WB.
  - sw: DMWr=1; on mem_rdy go to FETCH.
  - DMRd/DMWr stay asserted until mem_rdy.
- WB: RFWr=1.
  - WRSel: 01 for add/sub, 00 for ori/lui/lw.
  - WDSel: 01 for lw, 00 otherwise.
  - Then FETCH.
- Unlisted outputs are 0 in every state. Outputs are combinational from state and opcode/func, plus zero (beq) and mem_rdy (FETCH).

## Timing
- Reset (reset_n=0, asynchronous): state=FETCH. All enables and requests (PCWr, IRWr, RFWr, DMWr, DMRd, illegal) are forced 0 while reset is asserted. Selects are 0. instret=0.
- Reset release: the first FETCH cycle is the first clock with reset_n=1.
- Cycles with mem_rdy tied 1:
  - jal, jr: 2.
  - beq: 3.
  - add, sub, ori, lui, sw: 4.
  - lw: 5.
- Each cycle mem_rdy=0 in FETCH or MEM adds exactly one cycle.
- Reset mid-instruction abandons it. A pending sw drops DMWr immediately, and no RF/PC write occurs.
- beq not taken: PCWr=0. The PC keeps the PC+4 written in FETCH.

## Configuration
- MC_CTRL_INSTRET_EN defined: a 32-bit instret counter increments on the last cycle of each recognised instruction (the cycle whose next state is FETCH, excluding illegal). It wraps 0xFFFFFFFF→0.
- MC_CTRL_INSTRET_EN undefined: instret is tied to 0 and no counter flops exist.

## Structure
- Package mc_pkg holds:
  - state codes;
  - opcode/func constants (R=000000, add 100000, sub 100010, jr 001000, ori 001101, lw 100011, sw 101011, lui 001111, beq 000100, jal 000011);
  - ALUOP, WRSel, WDSel and NPCSel codes.
- Sub-module mc_decode: combinational opcode/func to one-hot instruction-class flags plus illegal. The FSM and output logic stay in mc_ctrl.

## Test plan
- Reset, then mem_rdy=1 with add (opcode 0, func 100000): states 0→1→2→4→0. RFWr=1 and WRSel=01 only in WB. PCWr/IRWr high only in FETCH.
- lw with mem_rdy low for 2 MEM cycles: DMRd held for 3 cycles. WB has WDSel=01 and WRSel=00. Total 7 cycles.
- beq with zero=1: PCWr=1 with NPCSel=01 in EXEC. With zero=0: PCWr=0. Both take 3 cycles.
- jal then jr: each takes 2 cycles. jal gives RFWr=1, WRSel=10, WDSel=10, NPCSel=10. jr gives NPCSel=11.
- Opcode 111111: illegal pulses once in DECODE, no writes, back to FETCH. instret is unchanged.
- reset_n low during sw MEM wait: DMWr drops asynchronously and state=0. With MC_CTRL_INSTRET_EN: 3 instructions retired gives instret=3, and a preload to 0xFFFFFFFF plus one retire wraps to 0.
